seq_mult_ctrl: RTL

SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

---
 rtl/seq_mult_pkg.sv | 18 +
 rtl/seq_mult_ctrl_if.sv | 27 ++
 rtl/mult_digit_2x2.sv | 10 +
 rtl/seq_mult_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential 2-bit-digit multiplier.
package seq_mult_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned DIGITS    = WIDTH_DEF / 2;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    // Digit-index counter width, never narrower than one bit.
    function automatic int unsigned cnt_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_mult_ctrl_if.sv
// Operand/product handshake bundle for seq_mult_ctrl.
interface seq_mult_ctrl_if
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid, op_a, op_b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, out_ready,
        output in_ready, out_valid, product, busy
    );

endinterface

// File: rtl/mult_digit_2x2.sv
// Combinational 2-bit by 2-bit unsigned digit multiplier.
module mult_digit_2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);

    assign p = {2'b00, a} * {2'b00, b};

endmodule

// File: rtl/seq_mult_ctrl.sv
// Iterative unsigned multiplier: one 2x2 digit partial product per CALC cycle,
// (WIDTH/2)^2 cycles per operation, valid/ready on both sides.
// Optional macro SEQ_MULT_EARLY_EXIT_EN: a zero operand skips CALC entirely.
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    seq_mult_ctrl_if.slave  bus
);

    localparam int unsigned    DIG  = WIDTH / 2;
    localparam int unsigned    CW   = cnt_bits(DIG);
    localparam logic [CW-1:0]  LAST = CW'(DIG - 1);

    state_e                state_q;
    logic [WIDTH-1:0]      a_q;
    logic [WIDTH-1:0]      b_q;
    logic [2*WIDTH-1:0]    acc_q;
    logic [2*WIDTH-1:0]    acc_d;
    logic [CW-1:0]         i_q;
    logic [CW-1:0]         j_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic                  busy_q;

    logic [WIDTH-1:0]      a_sh;
    logic [WIDTH-1:0]      b_sh;
    logic [1:0]            a_dig;
    logic [1:0]            b_dig;
    logic [3:0]            dig_p;
    logic [CW+1:0]         shamt;
    logic [2*WIDTH-1:0]    pp_sh;
    logic                  last_digit;

    mult_digit_2x2 u_digit (
        .a (a_dig),
        .b (b_dig),
        .p (dig_p)
    );

    // Select the current digits and align their product into the accumulator.
    always_comb begin
        a_sh       = a_q >> {i_q, 1'b0};
        b_sh       = b_q >> {j_q, 1'b0};
        a_dig      = a_sh[1:0];
        b_dig      = b_sh[1:0];
        shamt      = ({2'b00, i_q} + {2'b00, j_q}) << 1;
        pp_sh      = (2*WIDTH)'(dig_p) << shamt;
        acc_d      = acc_q + pp_sh;
        last_digit = (i_q == LAST) && (j_q == LAST);
    end

    // Control FSM with registered handshake outputs and datapath state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        a_q        <= bus.op_a;
                        b_q        <= bus.op_b;
                        i_q        <= '0;
                        j_q        <= '0;
                        acc_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef SEQ_MULT_EARLY_EXIT_EN
                        if (bus.op_a == '0 || bus.op_b == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= CALC;
                        end
`else
                        state_q <= CALC;
`endif
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    if (last_digit) begin
                        i_q         <= '0;
                        j_q         <= '0;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else if (j_q == LAST) begin
                        j_q <= '0;
                        i_q <= i_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.product   = acc_q;

endmodule
